// File: rtl/spi_rom_pkg.sv
// Shared SPI flash ROM protocol definitions: opcodes, field lengths, responder states.
// Latency: n/a (definitions only).
// Backpressure: n/a; imported by both the initiator and the responder side.
package spi_rom_pkg;
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_QREAD = 8'h6B;
    localparam int         CMD_LEN   = 8;
    localparam int         ADDR_LEN  = 24;

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, DUMMY, DATA1, DATA4, IGNORE
    } responder_state_t;
endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizer for {mosi, sclk, cs} plus CS/SCLK edge pulses.
// Latency: pins reach the pulse outputs after 2 clk; logic acts on the 3rd edge.
// Backpressure: none; the pins are sampled every clock.
module spi_pin_sync (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] pins,       // {mosi, sclk, cs}
    output logic       din,
    output logic       cs_rise,
    output logic       cs_fall,
    output logic       sclk_rise,
    output logic       sclk_fall
);
    logic [2:0] meta_q;
    logic [2:0] sync_q;
    logic       cs_q;
    logic       sclk_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= '0;
            sync_q <= '0;
            cs_q   <= 1'b0;
            sclk_q <= 1'b0;
        end else begin
            meta_q <= pins;
            sync_q <= meta_q;
            cs_q   <= sync_q[0];
            sclk_q <= sync_q[1];
        end
    end

    assign din       = sync_q[2];
    assign cs_rise   = sync_q[0] & ~cs_q;
    assign cs_fall   = ~sync_q[0] & cs_q;
    assign sclk_rise = sync_q[1] & ~sclk_q;
    assign sclk_fall = ~sync_q[1] & sclk_q;
endmodule

// File: rtl/spi_rom_responder.sv
// SPI flash stand-in serving 03h (and 6Bh with SPI_ROM_RESPONDER_QUAD_EN) from a sync byte memory.
// Latency: 3 clk pin-to-action; io updated <= 4 clk after SCLK fall; mem_rd to load 2 clk.
// Backpressure: none; the initiator owns SCLK, next byte is prefetched a full SCLK period early.
module spi_rom_responder
    import spi_rom_pkg::*;
#(
    parameter int ADDR_BITS    = 10,   // must be >= 8: the opcode shares the address shifter
    parameter int DUMMY_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 spi_cs,
    input  logic                 spi_sclk,
    input  logic                 spi_in0,
    output logic [3:0]           spi_out,
    output logic [3:0]           spi_oe,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_rd,
    input  logic [7:0]           mem_data,
    output logic                 cmd_error
);
    localparam int CNT_W = (DUMMY_CYCLES > ADDR_LEN) ? $clog2(DUMMY_CYCLES + 1) : 5;
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_LEN - 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_LEN - 1);
`ifdef SPI_ROM_RESPONDER_QUAD_EN
    localparam logic [CNT_W-1:0] DUMMY_LAST = CNT_W'(DUMMY_CYCLES - 1);
    localparam logic [3:0]       OE_MASK    = 4'b1111;
`else
    localparam logic [3:0]       OE_MASK    = 4'b0010;
`endif

    logic din, cs_rise, cs_fall, sclk_rise, sclk_fall;

    spi_pin_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .pins      ({spi_in0, spi_sclk, spi_cs}),
        .din       (din),
        .cs_rise   (cs_rise),
        .cs_fall   (cs_fall),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall)
    );

    responder_state_t     state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [ADDR_BITS-2:0] sh_q;
    logic [ADDR_BITS-1:0] shifted;
    logic                 rd_q;
    logic [7:0]           fetch_q;
    logic [7:0]           cur_q;
    logic [2:0]           bit_q;
    logic [3:0]           out_q;
    logic [3:0]           oe_q;
    logic                 addr_done;
    logic                 err_d;
`ifdef SPI_ROM_RESPONDER_QUAD_EN
    logic                 quad_q;
`endif

    // Only the low ADDR_BITS of the 24-bit address survive; upper bits shift out.
    assign shifted = {sh_q, din};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        err_d     = 1'b0;
        addr_done = 1'b0;
        if (cs_fall) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (cs_rise) state_d = CMD;
                CMD: begin
                    if (sclk_rise && cnt_q == CMD_LAST) begin
                        if (shifted[7:0] == CMD_READ) begin
                            state_d = ADDR;
`ifdef SPI_ROM_RESPONDER_QUAD_EN
                        end else if (shifted[7:0] == CMD_QREAD) begin
                            state_d = ADDR;
`endif
                        end else begin
                            state_d = IGNORE;
                            err_d   = 1'b1;
                        end
                    end
                end
                ADDR: begin
                    if (sclk_rise && cnt_q == ADDR_LAST) begin
                        addr_done = 1'b1;
`ifdef SPI_ROM_RESPONDER_QUAD_EN
                        state_d = quad_q ? ((DUMMY_CYCLES == 0) ? DATA4 : DUMMY) : DATA1;
`else
                        state_d = DATA1;
`endif
                    end
                end
`ifdef SPI_ROM_RESPONDER_QUAD_EN
                DUMMY: if (sclk_rise && cnt_q == DUMMY_LAST) state_d = DATA4;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            sh_q      <= '0;
            rd_q      <= 1'b0;
            fetch_q   <= '0;
            cur_q     <= '0;
            bit_q     <= '0;
            out_q     <= '0;
            oe_q      <= '0;
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
            cmd_error <= 1'b0;
`ifdef SPI_ROM_RESPONDER_QUAD_EN
            quad_q    <= 1'b0;
`endif
        end else begin
            mem_rd    <= 1'b0;
            cmd_error <= err_d;
            rd_q      <= mem_rd & ~cs_fall;
            if (rd_q) fetch_q <= mem_data;

            if (state_d != state_q) cnt_q <= '0;
            else if (sclk_rise)     cnt_q <= cnt_q + CNT_W'(1);

            if (sclk_rise && (state_q == CMD || state_q == ADDR))
                sh_q <= shifted[ADDR_BITS-2:0];
`ifdef SPI_ROM_RESPONDER_QUAD_EN
            if (state_q == CMD && state_d == ADDR)
                quad_q <= (shifted[7:0] == CMD_QREAD);
`endif
            if (addr_done) begin
                mem_addr <= shifted;
                mem_rd   <= 1'b1;
                bit_q    <= '0;
            end

            if (cs_fall) begin
                out_q <= '0;
                oe_q  <= '0;
            end else if (sclk_fall && state_q == DATA1) begin
                // Byte boundary takes the prefetched byte; later bits come from cur_q.
                if (bit_q == 3'd0) begin
                    out_q <= {2'b00, fetch_q[7], 1'b0};
                    cur_q <= {fetch_q[6:0], 1'b0};
                end else begin
                    out_q <= {2'b00, cur_q[7], 1'b0};
                    cur_q <= {cur_q[6:0], 1'b0};
                end
                oe_q  <= 4'b0010;
                bit_q <= bit_q + 3'd1;
                if (bit_q == 3'd7) begin
                    mem_addr <= mem_addr + ADDR_BITS'(1);
                    mem_rd   <= 1'b1;
                end
`ifdef SPI_ROM_RESPONDER_QUAD_EN
            end else if (sclk_fall && state_q == DATA4) begin
                if (!bit_q[0]) begin
                    out_q <= fetch_q[7:4];
                    cur_q <= fetch_q;
                end else begin
                    out_q    <= cur_q[3:0];
                    mem_addr <= mem_addr + ADDR_BITS'(1);
                    mem_rd   <= 1'b1;
                end
                oe_q  <= 4'b1111;
                bit_q <= {2'b00, ~bit_q[0]};
`endif
            end
        end
    end

    assign spi_out = out_q & OE_MASK;
    assign spi_oe  = oe_q & OE_MASK;
endmodule

// File: tb/tb_spi_rom_responder.sv
// Bench for spi_rom_responder: bit-banged SPI initiator with randomized SCLK phases and addresses,
// bytes compared against a plain array lookup mem[(addr + n) mod 1024].
module tb_spi_rom_responder;
    localparam int AB    = 10;
    localparam int DUMMY = 8;
`ifdef SPI_ROM_RESPONDER_QUAD_EN
    localparam bit HAS_QUAD = 1'b1;
`else
    localparam bit HAS_QUAD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          spi_cs;
    logic          spi_sclk;
    logic          spi_in0;
    logic [3:0]    spi_out;
    logic [3:0]    spi_oe;
    logic [AB-1:0] mem_addr;
    logic          mem_rd;
    logic [7:0]    mem_data;
    logic          cmd_error;

    logic [7:0] mem [0:1023];
    int total = 0;
    int bad = 0;
    int err_pulses = 0;
    int half = 4;

    always #5 clk = ~clk;

    spi_rom_responder #(.ADDR_BITS(AB), .DUMMY_CYCLES(DUMMY)) dut (
        .clk       (clk),
        .reset     (reset),
        .spi_cs    (spi_cs),
        .spi_sclk  (spi_sclk),
        .spi_in0   (spi_in0),
        .spi_out   (spi_out),
        .spi_oe    (spi_oe),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .cmd_error (cmd_error)
    );

    // Synchronous byte memory: data valid one clock after the read strobe.
    always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

    always @(negedge clk) if (cmd_error) err_pulses <= err_pulses + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One SCLK period: low phase (sample io just before the rise), then high phase.
    task automatic clk_bit(input logic mosi, output logic [3:0] io, output logic [3:0] oe);
        spi_in0 = mosi;
        repeat (half) @(posedge clk);
        #1 io = spi_out;
        oe = spi_oe;
        #1 spi_sclk = 1'b1;
        repeat (half) @(posedge clk);
        #2 spi_sclk = 1'b0;
    endtask

    task automatic start_txn(input logic [7:0] op, input logic [23:0] addr, input bit quad,
                             output logic [3:0] oe_or);
        logic [31:0] word;
        logic [3:0]  io, oe;
        half  = $urandom_range(4, 6);
        oe_or = '0;
        @(posedge clk);
        #2 spi_cs = 1'b1;
        word = {op, addr};
        for (int i = 31; i >= 0; i--) begin
            clk_bit(word[i], io, oe);
            oe_or |= oe;
        end
        if (quad) for (int i = 0; i < DUMMY; i++) begin
            clk_bit(1'b0, io, oe);
            oe_or |= oe;
        end
    endtask

    task automatic end_txn();
        spi_in0 = 1'b0;
        repeat (half) @(posedge clk);
        #2 spi_cs = 1'b0;
        repeat (8) @(posedge clk);
    endtask

    task automatic run_read(input logic [23:0] addr, input int nbytes, input bit quad);
        logic [3:0] io, oe, oe_first, oe_or;
        logic [7:0] got;
        int e0, idx;
        e0 = err_pulses;
        start_txn(quad ? 8'h6B : 8'h03, addr, quad, oe_or);
        for (int b = 0; b < nbytes; b++) begin
            got = '0;
            oe_first = '0;
            for (int k = 0; k < (quad ? 2 : 8); k++) begin
                clk_bit(1'b0, io, oe);
                if (k == 0) oe_first = oe;
                got = quad ? {got[3:0], io} : {got[6:0], io[1]};
            end
            idx = (int'(addr[AB-1:0]) + b) % 1024;
            if (quad) chk("quad_byte", got, mem[idx]);
            else      chk("single_byte", got, mem[idx]);
            chk("data_oe", oe_first, quad ? 4'hF : 4'h2);
        end
        end_txn();
        chk("no_cmd_error", err_pulses - e0, 0);
    endtask

    task automatic run_bad(input logic [7:0] op);
        logic [3:0] io, oe, oe_or;
        int e0;
        e0 = err_pulses;
        start_txn(op, 24'($urandom), 1'b0, oe_or);
        for (int i = 0; i < 8; i++) begin
            clk_bit(1'b0, io, oe);
            oe_or |= oe;
        end
        end_txn();
        chk("bad_op_pulses", err_pulses - e0, 1);
        chk("bad_op_oe", oe_or, 0);
    endtask

    initial begin
        logic [3:0] io, oe, oe_or;
        bit q;
        spi_cs   = 1'b0;
        spi_sclk = 1'b0;
        spi_in0  = 1'b0;
        reset    = 1'b0;
        mem_data = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        mem[16]  = 8'hA5;
        mem[17]  = 8'h3C;
        mem[64]  = 8'h9E;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", spi_out, 0);
        chk("rst_oe", spi_oe, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_rd", mem_rd, 0);
        chk("rst_err", cmd_error, 0);
        #1 reset = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk("idle_oe", spi_oe, 0);

        run_read(24'h000010, 2, 1'b0);
        run_read(24'h0003FF, 2, 1'b0);
        run_bad(8'h9F);
        run_read(24'h000123, 1, 1'b0);
`ifdef SPI_ROM_RESPONDER_QUAD_EN
        run_read(24'h000040, 1, 1'b1);
        run_read(24'h0003FF, 2, 1'b1);
`else
        run_bad(8'h6B);
`endif

        // CS dropped after 5 data bits.
        start_txn(8'h03, 24'h000055, 1'b0, oe_or);
        for (int i = 0; i < 5; i++) clk_bit(1'b0, io, oe);
        repeat (5) @(posedge clk);
        #1 chk("pre_drop_oe", spi_oe, 4'h2);
        @(posedge clk);
        #2 spi_cs = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("drop_oe", spi_oe, 0);
        chk("drop_out", spi_out, 0);
        repeat (8) @(posedge clk);

        for (int n = 0; n < 8; n++) begin
            q = HAS_QUAD && ($urandom_range(0, 1) == 1);
            run_read(24'($urandom), $urandom_range(1, 3), q);
        end

        // Reset in the middle of the data phase.
        start_txn(HAS_QUAD ? 8'h6B : 8'h03, 24'h000040, HAS_QUAD, oe_or);
        for (int i = 0; i < 3; i++) clk_bit(1'b0, io, oe);
        repeat (5) @(posedge clk);
        #1 chk("pre_rst_oe", spi_oe, HAS_QUAD ? 4'hF : 4'h2);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_out", spi_out, 0);
        chk("mid_rst_oe", spi_oe, 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_rd", mem_rd, 0);
        chk("mid_rst_err", cmd_error, 0);
        spi_cs   = 1'b0;
        spi_sclk = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        repeat (4) @(posedge clk);
        run_read(24'h000011, 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
